// File: rtl/mem_pkg.sv
// Shared types and default sizing for the word-wide RAM and its edit port.
package mem_pkg;

    localparam int MEM_AW_DEF  = 8;
    localparam int MEM_BW_DEF  = 8;
    localparam int MEM_BPW_DEF = 2;

    // Front-panel edit state machine.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        COMMIT = 2'd2
    } edit_state_t;

endpackage

// File: rtl/mem_word_ram_edit_sync.sv
// Two-flop synchroniser for an asynchronous switch/button input, plus a third
// flop so a rising edge can be turned into a single CLK-wide pulse.
module edit_sync (
    input  logic CLK,
    input  logic RST,
    input  logic async_in,
    output logic rise
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchroniser chain and delayed copy for edge detection.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/mem_word_ram.sv
// Byte-addressed RAM with big-endian multi-byte reads on a shared tristate
// bus, byte/word CPU writes, a front-panel edit port and a hardware clear.
//
// Edit port handshake: a rising edge on MEM_EDIT is a request; it is accepted
// only while the edit FSM is IDLE (address/data captured on that edge).
// MEM_BUSY stays high from acceptance until the write has been committed,
// MEM_ACK pulses for exactly one cycle after the commit write, and any edge
// arriving while a request is still outstanding is dropped and sets the
// sticky MEM_OVF flag.
module mem_word_ram
    import mem_pkg::*;
#(
    parameter int AW  = MEM_AW_DEF,
    parameter int BW  = MEM_BW_DEF,
    parameter int BPW = MEM_BPW_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              MSL,
    input  logic              MOE,
    input  logic              MWE,
    input  logic              MWW,
    input  logic [AW-1:0]     ADDR,
    inout  wire  [BW*BPW-1:0] DATA,
    input  logic [AW-1:0]     MEM_ADDR,
    input  logic [BW-1:0]     MEM_DATA,
    input  logic              MEM_EDIT,
    input  logic              MEM_CLR,
    output logic [BW-1:0]     MEM_RDATA,
    output logic              MEM_BUSY,
    output logic              MEM_ACK,
    output logic              MEM_OVF
);

    localparam int DEPTH = 2 ** AW;
    localparam int DW    = BW * BPW;

    logic [BW-1:0] mem [DEPTH];

    logic [DW-1:0] rd_next;
    logic [DW-1:0] rd_q;
    logic [BW-1:0] rdata_q;

    logic          edit_rise;
    edit_state_t   edit_state;
    edit_state_t   edit_next;
    logic          edit_commit;
    logic [AW-1:0] hold_addr;
    logic [BW-1:0] hold_data;

    logic          clr_active;
    logic          clr_armed;
    logic          clr_start;
    logic          clr_last;
    logic          clr_next;
    logic [AW-1:0] clr_cnt;

    logic          cpu_req;
    logic          cpu_we;
    logic          busy_q;
    logic          ack_q;
    logic          ovf_q;

    // The clear sweep owns the array; CPU writes are swallowed while it runs.
    assign cpu_req   = MSL & MWE;
    assign cpu_we    = cpu_req & ~clr_active;
    assign clr_start = MEM_CLR & ~clr_active & clr_armed;
    assign clr_last  = clr_active & (clr_cnt == {AW{1'b1}});
    assign clr_next  = clr_start | (clr_active & ~clr_last);

    edit_sync u_edit_sync (
        .CLK      (CLK),
        .RST      (RST),
        .async_in (MEM_EDIT),
        .rise     (edit_rise)
    );

    // Edit FSM state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            edit_state <= IDLE;
        end else begin
            edit_state <= edit_next;
        end
    end

    // Edit FSM next state; commit only in a cycle the array is otherwise free.
    always_comb begin
        edit_next   = edit_state;
        edit_commit = 1'b0;
        case (edit_state)
            IDLE: begin
                if (edit_rise) begin
                    edit_next = PEND;
                end
            end
            PEND: begin
                if (!cpu_req && !clr_active) begin
                    edit_commit = 1'b1;
                    edit_next   = COMMIT;
                end
            end
            COMMIT: begin
                edit_next = IDLE;
            end
            default: begin
                edit_next = IDLE;
            end
        endcase
    end

    // Capture the edit request on acceptance; flag strobes that arrive too soon.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hold_addr <= '0;
            hold_data <= '0;
            ovf_q     <= 1'b0;
        end else if (edit_rise) begin
            if (edit_state == IDLE) begin
                hold_addr <= MEM_ADDR;
                hold_data <= MEM_DATA;
            end else begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Clear sweep: counter walks 0..DEPTH-1, re-arms only after MEM_CLR drops.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            clr_active <= 1'b0;
            clr_cnt    <= '0;
            clr_armed  <= 1'b1;
        end else begin
            clr_active <= clr_next;
            if (clr_start) begin
                clr_cnt <= '0;
            end else if (clr_active) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
            if (clr_start) begin
                clr_armed <= 1'b0;
            end else if (!MEM_CLR) begin
                clr_armed <= 1'b1;
            end
        end
    end

    // Array writes: clear beats CPU beats edit; only a CPU word touches >1 byte.
    always_ff @(posedge CLK) begin
        if (clr_active) begin
            mem[clr_cnt] <= '0;
        end else if (cpu_we) begin
            if (MWW) begin
                for (int i = 0; i < BPW; i++) begin
                    mem[ADDR + AW'(i)] <= DATA[(BPW-1-i)*BW +: BW];
                end
            end else begin
                mem[ADDR] <= DATA[BW-1:0];
            end
        end else if (edit_commit) begin
            mem[hold_addr] <= hold_data;
        end
    end

    // Gather BPW consecutive bytes, lowest address in the MSBs, wrapping.
    always_comb begin
        rd_next = '0;
        for (int i = 0; i < BPW; i++) begin
            rd_next[(BPW-1-i)*BW +: BW] = mem[ADDR + AW'(i)];
        end
    end

    // Read register, edit-port readback and registered status outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_q    <= '0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            rd_q    <= rd_next;
            rdata_q <= mem[MEM_ADDR];
            busy_q  <= (edit_next != IDLE) | clr_next;
            ack_q   <= (edit_next == COMMIT);
        end
    end

    assign DATA      = (MSL & MOE) ? rd_q : {DW{1'bz}};
    assign MEM_RDATA = rdata_q;
    assign MEM_BUSY  = busy_q;
    assign MEM_ACK   = ack_q;
    assign MEM_OVF   = ovf_q;

endmodule

// File: tb/tb_mem_word_ram.sv
// Directed bench for mem_word_ram: bus reads/writes, wrap, edit handshake,
// overflow, clear sweep and reset abort.
module tb_mem_word_ram;

    logic        CLK = 1'b0;
    logic        RST;
    logic        MSL, MOE, MWE, MWW;
    logic [7:0]  ADDR;
    wire  [15:0] DATA;
    logic [7:0]  MEM_ADDR, MEM_DATA;
    logic        MEM_EDIT, MEM_CLR;
    logic [7:0]  MEM_RDATA;
    logic        MEM_BUSY, MEM_ACK, MEM_OVF;

    logic        drv_en;
    logic [15:0] drv_val;

    int total = 0;
    int bad   = 0;
    int busy_cnt;

    // Bench side of the shared bus; weak pull-up makes an undriven bus read FFFF.
    assign DATA = drv_en ? drv_val : 16'hzzzz;
    assign (weak0, weak1) DATA = 16'hFFFF;

    always #5 CLK = ~CLK;

    mem_word_ram #(.AW(8), .BW(8), .BPW(2)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .MSL       (MSL),
        .MOE       (MOE),
        .MWE       (MWE),
        .MWW       (MWW),
        .ADDR      (ADDR),
        .DATA      (DATA),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_DATA  (MEM_DATA),
        .MEM_EDIT  (MEM_EDIT),
        .MEM_CLR   (MEM_CLR),
        .MEM_RDATA (MEM_RDATA),
        .MEM_BUSY  (MEM_BUSY),
        .MEM_ACK   (MEM_ACK),
        .MEM_OVF   (MEM_OVF)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [15:0] d, input logic word);
        MSL = 1'b1; MOE = 1'b0; MWE = 1'b1; MWW = word; ADDR = a;
        drv_val = d; drv_en = 1'b1;
        step(1);
        MWE = 1'b0; drv_en = 1'b0;
    endtask

    task automatic cpu_read(input logic [7:0] a);
        MSL = 1'b1; MOE = 1'b1; MWE = 1'b0; ADDR = a;
        step(1);
    endtask

    initial begin
        RST = 1'b1; MSL = 1'b0; MOE = 1'b0; MWE = 1'b0; MWW = 1'b0; ADDR = '0;
        MEM_ADDR = '0; MEM_DATA = '0; MEM_EDIT = 1'b0; MEM_CLR = 1'b0;
        drv_en = 1'b0; drv_val = '0;
        step(2);

        // Reset state
        check("rst_busy", MEM_BUSY, 0);
        check("rst_ack", MEM_ACK, 0);
        check("rst_ovf", MEM_OVF, 0);
        check("rst_rdata", MEM_RDATA, 0);
        MSL = 1'b1; MOE = 1'b0; #1;
        check("rst_bus_float", DATA, 16'hFFFF);
        MOE = 1'b1; #1;
        check("rst_bus_rdreg", DATA, 16'h0000);
        MOE = 1'b0; RST = 1'b0;
        step(1);

        // Word write and big-endian read
        cpu_write(8'h10, 16'hABCD, 1'b1);
        cpu_read(8'h10);
        check("rd_word_10", DATA, 16'hABCD);
        MOE = 1'b0; #1;
        check("bus_float_moe0", DATA, 16'hFFFF);
        MSL = 1'b0; MOE = 1'b1; #1;
        check("bus_float_msl0", DATA, 16'hFFFF);
        cpu_read(8'h11);
        check("rd_word_11_hi", DATA[15:8], 8'hCD);

        // Word write wrapping from top of memory to 0
        cpu_write(8'hFF, 16'h1234, 1'b1);
        cpu_read(8'hFF);
        check("rd_wrap_ff", DATA, 16'h1234);
        cpu_read(8'h00);
        check("rd_00_hi", DATA[15:8], 8'h34);

        // Byte write touches only the addressed byte
        cpu_write(8'h11, 16'h9977, 1'b0);
        cpu_read(8'h10);
        check("rd_byte_wr", DATA, 16'hAB77);

        // Read during write returns old data
        cpu_write(8'h10, 16'h1111, 1'b1);
        MOE = 1'b1; #1;
        check("rdw_old", DATA, 16'hAB77);
        step(1);
        check("rdw_new", DATA, 16'h1111);

        // Edit-port readback
        MEM_ADDR = 8'h11;
        step(1);
        check("mem_rdata_11", MEM_RDATA, 8'h11);

        // Edit held off by back-to-back CPU writes, second strobe overflows
        MOE = 1'b0; MSL = 1'b1; MWE = 1'b1; MWW = 1'b0; ADDR = 8'h30;
        drv_val = 16'h00C3; drv_en = 1'b1;
        MEM_ADDR = 8'h20; MEM_DATA = 8'h5A;
        for (int i = 0; i < 10; i++) begin
            MEM_EDIT = (i < 3) || (i >= 6 && i < 9);
            if (i == 6) begin
                MEM_ADDR = 8'h21; MEM_DATA = 8'hA5;
            end
            step(1);
            if (i >= 2) begin
                check($sformatf("edit_busy_%0d", i), MEM_BUSY, 1);
                check($sformatf("edit_noack_%0d", i), MEM_ACK, 0);
            end
            if (i == 7) check("ovf_before", MEM_OVF, 0);
            if (i == 8) check("ovf_set", MEM_OVF, 1);
        end
        MWE = 1'b0; drv_en = 1'b0; MEM_ADDR = 8'h20;
        step(1);
        check("edit_ack", MEM_ACK, 1);
        check("edit_ack_busy", MEM_BUSY, 1);
        step(1);
        check("edit_ack_once", MEM_ACK, 0);
        check("edit_idle", MEM_BUSY, 0);
        check("edit_data", MEM_RDATA, 8'h5A);
        MEM_ADDR = 8'h30;
        step(1);
        check("cpu_during_edit", MEM_RDATA, 8'hC3);
        check("ovf_sticky", MEM_OVF, 1);

        // Clear sweep with a CPU write attempted mid-sweep
        MEM_CLR = 1'b1;
        step(1);
        MEM_CLR = 1'b0;
        busy_cnt = 0;
        for (int c = 0; c < 400; c++) begin
            if (!MEM_BUSY) break;
            busy_cnt++;
            if (busy_cnt == 100) cpu_write(8'h05, 16'hBEEF, 1'b1);
            else step(1);
        end
        check("clr_cycles", busy_cnt, 256);
        cpu_read(8'h05);
        check("clr_cpu_ignored", DATA, 16'h0000);
        cpu_read(8'h10);
        check("clr_10", DATA, 16'h0000);
        cpu_read(8'hFF);
        check("clr_ff_wrap", DATA, 16'h0000);
        MEM_ADDR = 8'h20;
        step(1);
        check("clr_edit_byte", MEM_RDATA, 8'h00);
        check("clr_ovf_sticky", MEM_OVF, 1);

        // Reset aborts a repeated sweep
        MOE = 1'b0; MEM_CLR = 1'b1;
        step(1);
        MEM_CLR = 1'b0;
        step(99);
        check("sweep2_busy", MEM_BUSY, 1);
        RST = 1'b1; #1;
        check("abort_busy", MEM_BUSY, 0);
        check("abort_ovf", MEM_OVF, 0);
        check("abort_ack", MEM_ACK, 0);
        step(1);
        RST = 1'b0;
        step(2);
        check("abort_stays_idle", MEM_BUSY, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_word_ram.md
Name: mem_word_ram

Overview:
- Parametrised successor to the CPU byte-addressed RAM.
- Big-endian multi-byte word reads over the shared tristate DATA bus.
- Byte or full-word CPU writes.
- Front-panel edit port synchronised into the CLK domain with a busy/ack handshake.
- Hardware clear sweep; sits on the CPU bus beside registers/ALU, with the edit port wired to board switches.

Parameters:
- AW, 8, address width; depth = 2**AW bytes.
- BW, 8, bits per byte location.
- BPW, 2, bytes per bus word; DATA width = BW*BPW.

Ports:
- CLK  in  1  system clock, all state on rising edge.
- RST  in  1  asynchronous, active-high reset.
- MSL  in  1  memory select.
- MOE  in  1  output enable; DATA driven when MSL&MOE.
- MWE  in  1  CPU write enable (qualified by MSL).
- MWW  in  1  write size: 0 = one byte, 1 = full BPW-byte word.
- ADDR  in  AW  CPU byte address.
- DATA  inout  BW*BPW  shared bus; high-Z on all bits when not driven.
- MEM_ADDR  in  AW  edit-port address (switches).
- MEM_DATA  in  BW  edit-port byte.
- MEM_EDIT  in  1  asynchronous edit strobe (button).
- MEM_CLR  in  1  synchronous clear request, level, sampled on CLK.
- MEM_RDATA  out  BW  registered readback of mem[MEM_ADDR].
- MEM_BUSY  out  1  edit pending or clear in progress.
- MEM_ACK  out  1  one-cycle pulse when an edit is committed.
- MEM_OVF  out  1  sticky: an edit strobe was dropped.

Behaviour:
- Reset:
  - Clears the read register, MEM_RDATA, MEM_BUSY, MEM_ACK, MEM_OVF, the synchroniser flops, the FSM (to IDLE) and the clear counter.
  - Array contents are not reset.
- Read:
  - Each cycle the read register loads {mem[ADDR], mem[ADDR+1], ..., mem[ADDR+BPW-1]}, with the lowest address in the MSBs.
  - Address arithmetic is modulo 2**AW: wraps from top to 0.
  - Latency is 1 cycle. DATA = read register when MSL&MOE, else all Z.
- Read-during-write (same cycle, overlapping address): returns old data.
- CPU write, when MSL&MWE on a rising edge and no clear is active:
  - MWW=0: mem[ADDR] <= DATA[BW-1:0].
  - MWW=1: byte i <= DATA slice for byte i, big-endian, addresses wrap.
- MEM_RDATA <= mem[MEM_ADDR] every cycle, 1-cycle latency.
- Edit path:
  - MEM_EDIT passes through a 2-flop synchroniser plus a third flop; a rising-edge detect produces a one-cycle edge pulse.
  - On the edge, MEM_ADDR and MEM_DATA are captured into holding regs.
- Edit FSM:
  - IDLE -> PEND on edge.
  - PEND -> COMMIT in the first cycle with no CPU write (MSL&MWE low) and no clear active; the holding byte is written that cycle.
  - COMMIT -> IDLE next cycle; MEM_ACK=1 for exactly that one cycle.
  - Edge while in PEND or COMMIT: the strobe is dropped, MEM_OVF set, holding regs unchanged.
- Clear sweep:
  - MEM_CLR high while not clearing starts the sweep.
  - An AW-bit counter writes 0 to mem[counter], 0 to 2**AW-1, one byte per cycle; takes 2**AW cycles, then stops.
  - The sweep is not retriggered until MEM_CLR has been seen low.
  - CPU writes during the sweep are ignored; reads still operate.
  - A pending edit waits and commits after the sweep.
- MEM_BUSY = (FSM != IDLE) | clear active, registered.
- Write priority: clear > CPU write > edit commit. Never two writes to the array in one cycle, except the multi-byte CPU word write.
- RST asserted mid-sweep or mid-edit aborts immediately. Partial contents remain and the pending edit is lost.

Decomposition:
- Shared package mem_pkg:
  - Edit FSM state enum (IDLE, PEND, COMMIT).
  - Default AW/BW/BPW constants.
- Sub-module edit_sync: 2-flop synchroniser plus rising-edge detect with reset. It is reused for other switch inputs.
- Array, read register, clear counter and FSM stay in mem_word_ram.

Test Plan:
- Reset, then MSL=1 MOE=0 -> DATA all Z. After MOE=1 -> DATA = read register, no X on control outputs.
- Write ADDR=0x10 MWW=1 DATA=0xABCD, then read 0x10 -> 0xABCD one cycle later. Read 0x11 -> 0xCDxx.
- Word write at ADDR=0xFF with DATA=0x1234 -> mem[0xFF]=0x12, mem[0x00]=0x34. Read 0xFF -> 0x1234 (wrap).
- Pulse MEM_EDIT with MEM_ADDR=0x20 MEM_DATA=0x5A while CPU writes every cycle for 10 cycles:
  - MEM_BUSY stays high.
  - Commit occurs on the first free cycle, then MEM_ACK pulses once.
  - MEM_RDATA at 0x20 = 0x5A.
- Second MEM_EDIT pulse while PEND -> MEM_OVF=1 and sticky until RST; first edit still commits.
- Assert MEM_CLR for 1 cycle:
  - MEM_BUSY held for 256 cycles; every byte reads 0.
  - A CPU write issued mid-sweep has no effect.
  - RST at cycle 100 of a repeated sweep -> MEM_BUSY=0 immediately.
